// File: rtl/c64_loader_pkg.sv
// Shared types and constants for the C64 ROM image loader: FSM states,
// header magic bytes and load_err codes.
package c64_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MAGIC0 = 3'd1,
    ST_MAGIC1 = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  localparam logic [7:0] MAGIC0_BYTE = 8'hC6;
  localparam logic [7:0] MAGIC1_BYTE = 8'h40;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_MAGIC   = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/load_checksum.sv
// Modulo-256 running sum of the image bytes; o_is_zero looks ahead at sum+i_byte
// so the loader can judge the checksum byte in the same cycle it arrives.
module load_checksum (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_add,
  input  logic [7:0] i_byte,
  output logic [7:0] o_sum,
  output logic       o_is_zero
);

  logic [7:0] r_sum;
  logic [7:0] w_next;

  assign w_next    = r_sum + i_byte;
  assign o_sum     = r_sum;
  assign o_is_zero = (w_next == 8'h00);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sum <= 8'h00;
    end else if (i_clear) begin
      r_sum <= 8'h00;
    end else if (i_add) begin
      r_sum <= w_next;
    end
  end

endmodule

// File: rtl/rom_image_loader.sv
// Copies a magic-prefixed, checksummed ROM image from the SPI byte stream into RAM.
// Each RAM write appears one cycle after its byte_valid; stalls longer than TIMEOUT_CYC abort.
module rom_image_loader
  import c64_loader_pkg::*;
#(
  parameter int LOAD_BYTES  = 20480,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        stream_en,
  output logic [14:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_we,
  output logic        cpu_hold,
  output logic        load_done,
  output logic [1:0]  load_err
);

  localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [14:0]     IDX_LAST = 15'(LOAD_BYTES - 1);

  state_t        r_state;
  logic [14:0]   r_idx;
  logic [TW-1:0] r_idle_cnt;
  logic          r_stream_en;
  logic [14:0]   r_ram_addr;
  logic [7:0]    r_ram_data;
  logic          r_ram_we;
  logic          r_cpu_hold;
  logic          r_load_done;
  logic [1:0]    r_load_err;

  logic       w_active;
  logic       w_restart;
  logic       w_sum_add;
  logic       w_sum_zero;
  logic [7:0] w_unused_sum;

  assign w_active  = (r_state == ST_MAGIC0) || (r_state == ST_MAGIC1) ||
                     (r_state == ST_DATA)   || (r_state == ST_CSUM);
  assign w_restart = start && ((r_state == ST_IDLE) || (r_state == ST_ERROR));
  assign w_sum_add = byte_valid && ((r_state == ST_DATA) || (r_state == ST_CSUM));

  load_checksum u_csum (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_restart),
    .i_add     (w_sum_add),
    .i_byte    (byte_in),
    .o_sum     (w_unused_sum),
    .o_is_zero (w_sum_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_idle_cnt  <= '0;
      r_stream_en <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
      r_ram_we    <= 1'b0;
      r_cpu_hold  <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= ERR_NONE;
    end else begin
      r_ram_we <= 1'b0;

      // Stall watchdog; a byte arriving on the limit cycle takes priority.
      if (w_active) begin
        if (byte_valid) begin
          r_idle_cnt <= '0;
        end else if (r_idle_cnt == TO_LAST) begin
          r_state     <= ST_ERROR;
          r_load_err  <= ERR_TIMEOUT;
          r_stream_en <= 1'b0;
        end else begin
          r_idle_cnt <= r_idle_cnt + TW'(1);
        end
      end

      case (r_state)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            r_state     <= ST_MAGIC0;
            r_stream_en <= 1'b1;
            r_load_err  <= ERR_NONE;
            r_idx       <= '0;
            r_idle_cnt  <= '0;
          end
        end
        ST_MAGIC0: begin
          if (byte_valid) begin
            if (byte_in == MAGIC0_BYTE) begin
              r_state <= ST_MAGIC1;
            end else begin
              r_state     <= ST_ERROR;
              r_load_err  <= ERR_MAGIC;
              r_stream_en <= 1'b0;
            end
          end
        end
        ST_MAGIC1: begin
          if (byte_valid) begin
            if (byte_in == MAGIC1_BYTE) begin
              r_state <= ST_DATA;
            end else begin
              r_state     <= ST_ERROR;
              r_load_err  <= ERR_MAGIC;
              r_stream_en <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (byte_valid) begin
            r_ram_we   <= 1'b1;
            r_ram_addr <= r_idx;
            r_ram_data <= byte_in;
            if (r_idx == IDX_LAST) begin
              r_state <= ST_CSUM;
            end else begin
              r_idx <= r_idx + 15'd1;
            end
          end
        end
        ST_CSUM: begin
          if (byte_valid) begin
            r_stream_en <= 1'b0;
            if (w_sum_zero) begin
              r_state     <= ST_DONE;
              r_cpu_hold  <= 1'b0;
              r_load_done <= 1'b1;
            end else begin
              r_state    <= ST_ERROR;
              r_load_err <= ERR_CSUM;
            end
          end
        end
        ST_DONE: begin
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign stream_en = r_stream_en;
  assign ram_addr  = r_ram_addr;
  assign ram_data  = r_ram_data;
  assign ram_we    = r_ram_we;
  assign cpu_hold  = r_cpu_hold;
  assign load_done = r_load_done;
  assign load_err  = r_load_err;

endmodule

// File: doc/rom_image_loader.md
ROM_IMAGE_LOADER -- requirements
Module: rom_image_loader

Interface
REQ-001 SHALL have parameter LOAD_BYTES, default 20480, meaning payload bytes to copy (8K BASIC + 8K KERNAL + 4K CHARGEN).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1048576, meaning the maximum number of idle clk cycles between stream bytes.
REQ-003 SHALL have ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- start  in  1  level or pulse; begins a load from IDLE.
- byte_in  in  8  byte from the SPI flash reader.
- byte_valid  in  1  one-cycle strobe qualifying byte_in.
- stream_en  out  1  requests the SPI reader to stream.
- ram_addr  out  15  RAM write address.
- ram_data  out  8  RAM write data.
- ram_we  out  1  one-cycle write strobe.
- cpu_hold  out  1  holds the C64 core in reset until the image is good.
- load_done  out  1  image loaded and verified.
- load_err  out  2  00 none, 01 bad magic, 10 checksum, 11 timeout.

Function
REQ-004 SHALL use states IDLE, MAGIC0, MAGIC1, DATA, CSUM, DONE, ERROR.
REQ-005 SHALL move IDLE->MAGIC0 on start=1 and assert stream_en from the next cycle.
- stream_en is asserted in MAGIC0, MAGIC1, DATA and CSUM only.
REQ-006 SHALL check the MAGIC0 byte against 0xC6 and the MAGIC1 byte against 0x40.
- On mismatch: go to ERROR with load_err=01.
REQ-007 SHALL treat each of the LOAD_BYTES bytes in DATA as payload:
- ram_data=byte_in, ram_addr=current index, ram_we=1 exactly one cycle after the byte_valid cycle.
- Index starts at 0 and increments by 1 per byte.
REQ-008 SHALL keep an 8-bit modulo-256 running sum of payload bytes; magic bytes are excluded.
REQ-009 SHALL move DATA->CSUM when the payload byte with index LOAD_BYTES-1 is accepted.
- The index SHALL NOT wrap; no write occurs beyond index LOAD_BYTES-1.
REQ-010 SHALL in CSUM add the received byte to the sum:
- Result 0x00: go to DONE.
- Otherwise: go to ERROR with load_err=10.
REQ-011 SHALL count cycles without byte_valid in MAGIC0..CSUM and reset the count on each byte_valid.
- Reaching TIMEOUT_CYC: go to ERROR with load_err=11.
- A byte_valid in the same cycle the limit is reached wins: the byte is accepted and there is no timeout.
REQ-012 SHALL ignore byte_valid in IDLE, DONE and ERROR; no ram_we is produced in those states.
REQ-013 SHALL ignore start outside IDLE and ERROR.
- start in ERROR restarts at MAGIC0 with load_err cleared and index and sum zeroed.
REQ-014 SHALL drive cpu_hold=1 in every state except DONE, and load_done=1 only in DONE.
- DONE is terminal until reset.

Reset
REQ-015 SHALL, while reset=0 at a rising clk edge, enter IDLE with: stream_en=0, ram_we=0, ram_addr=0, ram_data=0, cpu_hold=1, load_done=0, load_err=00, sum=0, timeout counter=0.
REQ-016 SHALL abort a load on reset mid-operation with no further ram_we; RAM contents are not cleared.

Structure
REQ-017 SHALL place the state enumeration, the MAGIC0/MAGIC1 constants and the load_err codes in the shared package c64_loader_pkg.
REQ-018 SHALL implement the sum and the zero check in one sub-module, load_checksum (clear, add strobe, byte in, sum out, is_zero).

Verification
REQ-019 SHALL cover these directed scenarios:
- Good image: LOAD_BYTES=16, stream C6 40, 01..10 (sum 0x88), 78 -> 16 writes to addresses 0..15, then load_done=1, cpu_hold=0, load_err=00.
- Bad magic: stream C6 41 -> ERROR, load_err=01, zero ram_we, stream_en=0.
- Bad checksum: good image with a last byte of 79 -> load_err=10, cpu_hold=1 after all 16 writes.
- Timeout: TIMEOUT_CYC=8, stop after 5 payload bytes -> load_err=11 on the 8th idle cycle.
- Reset mid-load: reset=0 after payload byte 3 -> IDLE next edge, no further writes; a fresh start with a good image reaches DONE.
- Extra bytes: byte_valid pulses in DONE -> ram_we stays 0 and load_done stays 1.
